// File: rtl/adc_sample_scheduler.sv
// Conversion scheduler for the MCP3002 SPI leader: periodic scan plus single-shot
// requests, a conversion timeout, and a 2-entry channel-tagged result FIFO.
module adc_sample_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 50000,
    parameter logic [1:0]  CH_MASK        = 2'b11,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        enable,
    input  logic        req_valid,
    input  logic        req_chan,
    output logic        req_ready,
    output logic        conv_start,
    output logic        conv_chan,
    input  logic        conv_busy,
    input  logic        conv_done,
    input  logic [9:0]  conv_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [10:0] sample_data,
    output logic        scan_overrun,
    output logic        timeout_err,
    output logic [7:0]  drop_count
);

    localparam int unsigned PW = $clog2(PERIOD_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] period_q;
    logic [TW-1:0] tcnt_q;
    logic [1:0]    pend_q;
    logic          sel_chan_q;
    logic          sel_req_q;
    logic          valid0_q;
    logic          valid1_q;
    logic [10:0]   data0_q;
    logic [10:0]   data1_q;
    logic [7:0]    drop_q;
    logic          ovr_q;

    logic          tick_c;
    logic          grant_c;
    logic          grant_chan_c;
    logic          grant_req_c;
    logic          fifo_wr_c;
    logic          abort_c;
    logic          pop_c;
    logic [10:0]   wr_word_c;

    assign tick_c    = enable && (period_q == PW'(PERIOD_CYCLES - 1));
    assign pop_c     = valid0_q && sample_ready;
    assign wr_word_c = {sel_chan_q, conv_data};

    // Next state: fixed-priority arbitration in IDLE, timeout/done handling in WAIT
    always_comb begin
        state_d      = state_q;
        grant_c      = 1'b0;
        grant_chan_c = 1'b0;
        grant_req_c  = 1'b0;
        fifo_wr_c    = 1'b0;
        abort_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!conv_busy) begin
                    if (pend_q[0]) begin
                        grant_c = 1'b1;
                    end else if (pend_q[1]) begin
                        grant_c      = 1'b1;
                        grant_chan_c = 1'b1;
                    end else if (req_valid) begin
                        grant_c      = 1'b1;
                        grant_chan_c = req_chan;
                        grant_req_c  = 1'b1;
                    end
                end
                if (grant_c) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (conv_done) begin
                    fifo_wr_c = 1'b1;
                    state_d   = IDLE;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 2)) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake acknowledges the request in the very cycle it wins arbitration
    assign req_ready    = grant_req_c;
    assign conv_chan    = sel_chan_q;
    assign sample_valid = valid0_q;
    assign sample_data  = data0_q;
    assign scan_overrun = ovr_q;
    assign drop_count   = drop_q;

    // State, timers and scan bookkeeping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            period_q    <= '0;
            tcnt_q      <= '0;
            pend_q      <= 2'b00;
            sel_chan_q  <= 1'b0;
            sel_req_q   <= 1'b0;
            conv_start  <= 1'b0;
            timeout_err <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_start  <= (state_d == ISSUE);
            timeout_err <= abort_c;
            if (grant_c) begin
                sel_chan_q <= grant_chan_c;
                sel_req_q  <= grant_req_c;
            end
            if (!enable || tick_c) period_q <= '0;
            else                   period_q <= period_q + PW'(1);
            if (state_q == ISSUE)     tcnt_q <= '0;
            else if (state_q == WAIT) tcnt_q <= tcnt_q + TW'(1);
            // A tick reloads the scan; it wins over clearing the issued channel
            if (tick_c) begin
                if (pend_q != 2'b00) ovr_q <= 1'b1;
                pend_q <= CH_MASK;
            end else if (state_q == ISSUE && !sel_req_q) begin
                pend_q[sel_chan_q] <= 1'b0;
            end
        end
    end

    // Two-entry fall-through FIFO; data0 is always the head
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            drop_q   <= '0;
        end else if (pop_c && fifo_wr_c) begin
            if (valid1_q) begin
                data0_q <= data1_q;
                data1_q <= wr_word_c;
            end else begin
                data0_q <= wr_word_c;
            end
        end else if (pop_c) begin
            data0_q  <= data1_q;
            valid0_q <= valid1_q;
            valid1_q <= 1'b0;
        end else if (fifo_wr_c) begin
            if (!valid0_q) begin
                data0_q  <= wr_word_c;
                valid0_q <= 1'b1;
            end else if (!valid1_q) begin
                data1_q  <= wr_word_c;
                valid1_q <= 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of scan, requests and result FIFO.
module tb_adc_sample_scheduler;

    localparam int unsigned PERIOD  = 100;
    localparam logic [1:0]  MASK    = 2'b11;
    localparam int unsigned TIMEOUT = 1024;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        enable;
    logic        req_valid;
    logic        req_chan;
    logic        req_ready;
    logic        conv_start;
    logic        conv_chan;
    logic        conv_busy;
    logic        conv_done;
    logic [9:0]  conv_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [10:0] sample_data;
    logic        scan_overrun;
    logic        timeout_err;
    logic [7:0]  drop_count;

    adc_sample_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .CH_MASK       (MASK),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_chan    (req_chan),
        .req_ready   (req_ready),
        .conv_start  (conv_start),
        .conv_chan   (conv_chan),
        .conv_busy   (conv_busy),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_data (sample_data),
        .scan_overrun(scan_overrun),
        .timeout_err (timeout_err),
        .drop_count  (drop_count)
    );

    always #10 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // SPI responder knobs
    int         done_at    = -1;
    logic [9:0] resp_data  = '0;
    int         lat        = 40;
    bit         fixed_data = 1'b0;
    int         suppress_n = 0;
    bit         force_busy = 1'b0;
    int         sr_mode    = 1;
    bit         rand_mode  = 1'b0;

    // Reference model
    logic [10:0] mq[$];
    logic [1:0]  m_pend    = 2'b00;
    bit          m_inconv  = 1'b0;
    int          m_start   = 0;
    logic        m_chan    = 1'b0;
    bit          m_ovr     = 1'b0;
    int          m_drop    = 0;
    int          m_ecnt    = 0;
    bit          exp_start = 1'b0;
    logic        exp_chan  = 1'b0;
    bit          exp_req   = 1'b0;
    bit          exp_to    = 1'b0;
    bit          req_taken = 1'b0;

    logic start_log[$];
    int   n_req_ready = 0;
    int   n_timeouts  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, predict the next edge
    task automatic step();
        bit   pop;
        bit   wr;
        bit   abort;
        bit   tick;
        bit   arb;
        logic ach;
        bit   areq;
        if (req_taken) begin
            req_valid = 1'b0;
            req_taken = 1'b0;
        end
        check("conv_start", conv_start, exp_start);
        if (exp_start) check("conv_chan", conv_chan, exp_chan);
        check("timeout_err", timeout_err, exp_to);
        check("sample_valid", sample_valid, mq.size() != 0);
        if (mq.size() != 0) check("sample_data", sample_data, mq[0]);
        check("drop_count", drop_count, m_drop);
        check("scan_overrun", scan_overrun, m_ovr);
        if (timeout_err) n_timeouts++;

        if (conv_start) begin
            if (suppress_n > 0) begin
                suppress_n--;
                done_at = -1;
            end else begin
                done_at = cyc + ((lat == 0) ? int'($urandom_range(1, 60)) : lat);
            end
            resp_data = fixed_data ? (conv_chan ? 10'h2AA : 10'h155) : 10'($urandom_range(0, 1023));
            start_log.push_back(conv_chan);
        end
        if (exp_start) begin
            m_inconv = 1'b1;
            m_start  = cyc;
            m_chan   = exp_chan;
        end

        if (rand_mode) begin
            force_busy = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if (!req_valid && $urandom_range(0, 15) == 0) begin
                req_chan  = 1'($urandom_range(0, 1));
                req_valid = 1'b1;
            end
        end
        conv_done = (cyc == done_at);
        conv_data = conv_done ? resp_data : 10'($urandom_range(0, 1023));
        conv_busy = force_busy || (done_at > cyc);
        case (sr_mode)
            0:       sample_ready = 1'b0;
            1:       sample_ready = 1'b1;
            default: sample_ready = 1'($urandom_range(0, 1));
        endcase
        #1;

        // Work is granted when idle and the leader is free: CH0, CH1, then request
        arb  = !m_inconv && !conv_busy && ((m_pend != 2'b00) || req_valid);
        ach  = m_pend[0] ? 1'b0 : (m_pend[1] ? 1'b1 : req_chan);
        areq = (m_pend == 2'b00);
        if (!RESET) begin
            check("req_ready", req_ready, arb && areq);
            if (req_ready) n_req_ready++;
        end

        pop   = (mq.size() != 0) && sample_ready;
        wr    = 1'b0;
        abort = 1'b0;
        if (m_inconv && cyc > m_start) begin
            if (conv_done) begin
                wr       = 1'b1;
                m_inconv = 1'b0;
            end else if (cyc - m_start == TIMEOUT - 1) begin
                abort    = 1'b1;
                m_inconv = 1'b0;
            end
        end
        tick   = enable && (m_ecnt == PERIOD - 1);
        m_ecnt = (!enable || tick) ? 0 : m_ecnt + 1;
        if (tick) begin
            if (m_pend != 2'b00) m_ovr = 1'b1;
            m_pend = MASK;
        end else if (exp_start && !exp_req) begin
            m_pend[exp_chan] = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (wr) begin
            if (mq.size() < 2) mq.push_back({m_chan, conv_data});
            else if (m_drop < 255) m_drop++;
        end
        exp_start = arb;
        exp_chan  = ach;
        exp_req   = areq;
        exp_to    = abort;
        if (arb && areq) req_taken = 1'b1;
        if (RESET) begin
            mq.delete();
            m_pend    = 2'b00;
            m_inconv  = 1'b0;
            m_ovr     = 1'b0;
            m_drop    = 0;
            m_ecnt    = 0;
            exp_start = 1'b0;
            exp_chan  = 1'b0;
            exp_to    = 1'b0;
            req_taken = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_conv_start"}, conv_start, 0);
        check({tag, "_conv_chan"}, conv_chan, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_sample_data"}, sample_data, 0);
        check({tag, "_overrun"}, scan_overrun, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_drops"}, drop_count, 0);
    endtask

    task automatic do_reset();
        req_valid  = 1'b0;
        enable     = 1'b0;
        force_busy = 1'b0;
        rand_mode  = 1'b0;
        suppress_n = 0;
        done_at    = -1;
        sr_mode    = 1;
        RESET      = 1'b1;
        run(2);
        check_all_zero("rst");
        RESET = 1'b0;
    endtask

    task automatic send_req(input logic ch);
        int k;
        req_chan  = ch;
        req_valid = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while ((req_valid || m_inconv || exp_start) && k < 200);
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_req: request not completed within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        logic [10:0] sd;
        RESET        = 1'b1;
        enable       = 1'b0;
        req_valid    = 1'b0;
        req_chan     = 1'b0;
        conv_busy    = 1'b0;
        conv_done    = 1'b0;
        conv_data    = '0;
        sample_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Periodic scan, fixed data, no overrun
        do_reset();
        lat = 40;
        fixed_data = 1'b1;
        enable = 1'b1;
        start_log.delete();
        run(350);
        check("scan_starts", start_log.size(), 6);
        foreach (start_log[i]) check("scan_order", start_log[i], i % 2);
        enable = 1'b0;
        run(60);
        check("scan_no_overrun", scan_overrun, 0);

        // Single-shot request with scanning disabled
        do_reset();
        lat = 0;
        fixed_data = 1'b0;
        n_req_ready = 0;
        start_log.delete();
        req_chan  = 1'b1;
        req_valid = 1'b1;
        run(80);
        check("sw_ready_pulses", n_req_ready, 1);
        check("sw_starts", start_log.size(), 1);
        if (start_log.size() == 1) check("sw_chan", start_log[0], 1);

        // Scan and request pending together: CH0, CH1, then request
        do_reset();
        sr_mode = 2;
        force_busy = 1'b1;
        enable = 1'b1;
        run(105);
        enable = 1'b0;
        req_chan  = 1'($urandom_range(0, 1));
        req_valid = 1'b1;
        run(3);
        force_busy = 1'b0;
        n_req_ready = 0;
        start_log.delete();
        run(250);
        check("mix_starts", start_log.size(), 3);
        if (start_log.size() == 3) begin
            check("mix_first", start_log[0], 0);
            check("mix_second", start_log[1], 1);
            check("mix_third", start_log[2], req_chan);
        end
        check("mix_ready_pulses", n_req_ready, 1);

        // Timeout on CH0, then CH1 proceeds normally
        do_reset();
        lat = 40;
        sr_mode = 0;
        suppress_n = 1;
        n_timeouts = 0;
        start_log.delete();
        enable = 1'b1;
        run(103);
        enable = 1'b0;
        run(1100);
        check("to_pulses", n_timeouts, 1);
        check("to_starts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            check("to_first", start_log[0], 0);
            check("to_second", start_log[1], 1);
        end
        sd = sample_data;
        check("to_sample_valid", sample_valid, 1);
        check("to_sample_chan", sd[10], 1);

        // FIFO full: one drop, drain in order, then saturation
        do_reset();
        sr_mode = 0;
        lat = 0;
        for (int i = 0; i < 3; i++) send_req(1'($urandom_range(0, 1)));
        run(2);
        check("fifo_drop1", drop_count, 1);
        sr_mode = 1;
        run(4);
        check("fifo_drained", sample_valid, 0);
        sr_mode = 0;
        lat = 1;
        for (int i = 0; i < 302; i++) send_req(1'($urandom_range(0, 1)));
        run(2);
        check("fifo_drop_sat", drop_count, 255);

        // Reset while waiting, with a late conv_done afterwards
        do_reset();
        lat = 40;
        req_chan  = 1'b0;
        req_valid = 1'b1;
        run(12);
        RESET = 1'b1;
        step();
        check_all_zero("midrst");
        RESET = 1'b0;
        run(60);
        check("midrst_empty", sample_valid, 0);
        check("midrst_drops", drop_count, 0);

        // Scan slower than the period sets a sticky overrun
        do_reset();
        lat = 60;
        enable = 1'b1;
        run(400);
        check("ovr_set", scan_overrun, 1);
        enable = 1'b0;
        run(200);
        check("ovr_sticky", scan_overrun, 1);

        // Random traffic
        do_reset();
        lat = 0;
        sr_mode = 2;
        enable = 1'b1;
        rand_mode = 1'b1;
        run(4000);
        rand_mode = 1'b0;
        force_busy = 1'b0;
        enable = 1'b0;
        run(200);

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
